// File: rtl/demux_stream_1to4.sv
// demux_stream_1to4
//   Routes one valid/ready stream of N-bit words to one of four single-word
//   output lanes. The destination is either in_sel (auto_mode=0) or an
//   internal round-robin pointer (auto_mode=1). A lane that is blocked
//   stalls only words aimed at it.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake; in_data word, in_sel explicit lane
//   auto_mode           1: destination = rr_ptr, 0: destination = in_sel
//   out_valid[i]        lane i holds a word; out_ready[i] lane i consumer takes it
//   out_data0..3        held word of each lane
//   rr_ptr              current round-robin destination
//   xfer_count          accepted input words, wraps modulo 2^16
module demux_stream_1to4 #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [1:0]   in_sel,
  input  logic         auto_mode,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ready,
  output logic [N-1:0] out_data0,
  output logic [N-1:0] out_data1,
  output logic [N-1:0] out_data2,
  output logic [N-1:0] out_data3,
  output logic [1:0]   rr_ptr,
  output logic [15:0]  xfer_count
);

  logic [1:0]   dest;
  logic [3:0]   lane_free;
  logic         accept;
  logic [N-1:0] lane_data [4];

  // A full lane that drains this cycle can take a new word on the same edge,
  // which keeps back-to-back traffic to one lane at full rate.
  always_comb begin
    dest      = auto_mode ? rr_ptr : in_sel;
    lane_free = ~out_valid | out_ready;
    in_ready  = lane_free[dest];
    accept    = in_valid & in_ready;
  end

  // Lane registers: reload has priority over drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 4'b0000;
      for (int i = 0; i < 4; i++) lane_data[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept && (dest == 2'(i))) begin
          out_valid[i] <= 1'b1;
          lane_data[i] <= in_data;
        end else if (out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer moves only on auto-mode accepts; lanes are never skipped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= 2'd0;
      xfer_count <= 16'd0;
    end else if (accept) begin
      xfer_count <= xfer_count + 16'd1;
      if (auto_mode) rr_ptr <= rr_ptr + 2'd1;
    end
  end

  assign out_data0 = lane_data[0];
  assign out_data1 = lane_data[1];
  assign out_data2 = lane_data[2];
  assign out_data3 = lane_data[3];

endmodule

// File: tb/tb_demux_stream_1to4.sv
module tb_demux_stream_1to4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        auto_mode;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] out_data0, out_data1, out_data2, out_data3;
  logic [1:0]  rr_ptr;
  logic [15:0] xfer_count;

  demux_stream_1to4 #(.N(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .auto_mode(auto_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1),
    .out_data2(out_data2), .out_data3(out_data3),
    .rr_ptr(rr_ptr), .xfer_count(xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each lane is a queue of words owed to its consumer,
  // plus a round-robin counter and an accept counter.
  logic [15:0] q [4][$];
  logic [1:0]  m_rr;
  logic [15:0] m_cnt;
  logic        rand_rdy;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] lane_word(input int i);
    case (i)
      0: return out_data0;
      1: return out_data1;
      2: return out_data2;
      default: return out_data3;
    endcase
  endfunction

  // Monitor: checks the DUT against the model and retires drained words.
  always @(negedge clk) begin : mon
    logic [1:0] d;
    logic       exp_rdy;
    if (!rst) begin
      d = auto_mode ? m_rr : in_sel;
      exp_rdy = (q[d].size() == 0) || out_ready[d];
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      chk("xfer_count", {16'd0, xfer_count}, {16'd0, m_cnt});
      chk("rr_ptr", {30'd0, rr_ptr}, {30'd0, m_rr});
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("out_valid[%0d]", i), {31'd0, out_valid[i]},
            {31'd0, q[i].size() != 0});
        if (q[i].size() != 0) begin
          chk($sformatf("out_data%0d", i), {16'd0, lane_word(i)}, {16'd0, q[i][0]});
          if (out_ready[i]) void'(q[i].pop_front());
        end
      end
    end
  end

  // Present a word and hold it until accepted; record it in the model on the
  // accepting edge. Returns with time at edge+1.
  task automatic send(input logic [15:0] d, input logic [1:0] s, input logic a,
                      output int waits);
    waits = 0;
    in_valid = 1'b1; in_data = d; in_sel = s; auto_mode = a;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 200) begin
        chk("accept_timeout", 32'(waits), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (rand_rdy) out_ready = 4'($urandom);
    end
    @(posedge clk);
    if (a) begin
      q[m_rr].push_back(d);
      m_rr = m_rr + 2'd1;
    end else begin
      q[s].push_back(d);
    end
    m_cnt = m_cnt + 16'd1;
    #1;
    in_valid = 1'b0;
    if (rand_rdy) out_ready = 4'($urandom);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = 4'($urandom);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) q[i].delete();
    m_rr = 2'd0;
    m_cnt = 16'd0;
  endtask

  initial begin
    int w;
    rand_rdy = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_data = 16'd0; in_sel = 2'd0;
    auto_mode = 1'b0; out_ready = 4'b0000;
    model_reset();
    @(posedge clk); #1;
    // Reset state
    chk("rst out_valid", {28'd0, out_valid}, 32'd0);
    chk("rst rr_ptr", {30'd0, rr_ptr}, 32'd0);
    chk("rst xfer_count", {16'd0, xfer_count}, 32'd0);
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst out_data", {out_data0 | out_data1 | out_data2 | out_data3}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Explicit routing
    out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      send(16'hA000 + 16'(i), 2'(i), 1'b0, w);
      chk("route valid", {31'd0, out_valid[i]}, 32'd1);
      chk("route data", {16'd0, lane_word(i)}, {16'd0, 16'hA000 + 16'(i)});
    end
    idle(2);
    chk("route count", {16'd0, xfer_count}, 32'd4);
    chk("route rr", {30'd0, rr_ptr}, 32'd0);

    // Backpressure isolation
    out_ready = 4'b1101;
    send(16'h1111, 2'd1, 1'b0, w);
    in_valid = 1'b1; in_data = 16'h2222; in_sel = 2'd1;
    @(negedge clk); chk("bp blocked", {31'd0, in_ready}, 32'd0);
    @(negedge clk); chk("bp blocked2", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    send(16'h3333, 2'd2, 1'b0, w);
    chk("bp other lane waits", 32'(w), 32'd0);
    chk("bp lane1 held", {16'd0, out_data1}, 32'h1111);
    out_ready = 4'b1111;
    send(16'h2222, 2'd1, 1'b0, w);
    chk("bp release same cycle", 32'(w), 32'd0);
    idle(2);

    // Pass-through on a full lane
    out_ready = 4'b1110;
    send(16'hAAAA, 2'd0, 1'b0, w);
    idle(1);
    out_ready = 4'b1111;
    send(16'hBEEF, 2'd0, 1'b0, w);
    chk("pt waits", 32'(w), 32'd0);
    chk("pt valid", {31'd0, out_valid[0]}, 32'd1);
    chk("pt data", {16'd0, out_data0}, 32'hBEEF);
    idle(2);

    // Round robin: rr_ptr is 0 here
    for (int k = 0; k < 6; k++) begin
      send(16'(k), 2'd3, 1'b1, w);
      chk("rr lane", {16'd0, lane_word(k % 4)}, 32'(k));
    end
    idle(1);
    chk("rr end", {30'd0, rr_ptr}, 32'd2);
    out_ready = 4'b1011;
    send(16'h5A5A, 2'd2, 1'b0, w);
    in_valid = 1'b1; in_data = 16'h7777; auto_mode = 1'b1; in_sel = 2'd0;
    repeat (3) begin
      @(negedge clk);
      chk("rr stall ready", {31'd0, in_ready}, 32'd0);
      chk("rr stall ptr", {30'd0, rr_ptr}, 32'd2);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 4'b1111;
    idle(2);

    // Async reset mid-stream with lanes 0 and 3 full
    out_ready = 4'b0000;
    send(16'hC0C0, 2'd0, 1'b0, w);
    send(16'hC3C3, 2'd3, 1'b0, w);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst out_valid", {28'd0, out_valid}, 32'd0);
    chk("arst rr_ptr", {30'd0, rr_ptr}, 32'd0);
    chk("arst xfer_count", {16'd0, xfer_count}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 4'b1111;

    // Counter wrap
    for (int k = 0; k < 65536; k++) send(16'(k), 2'd0, 1'b1, w);
    idle(1);
    chk("wrap count", {16'd0, xfer_count}, 32'd0);

    // Randomized traffic
    rand_rdy = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(3) == 0) idle(1);
      else send(16'($urandom), 2'($urandom), 1'($urandom), w);
    end
    rand_rdy = 1'b0;
    out_ready = 4'b1111;
    idle(3);
    for (int i = 0; i < 4; i++) chk("final drain", 32'(q[i].size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
